// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: strobe-captured words, show-ahead VALID/READY output,
// fill level and sticky overrun. Optional WMARK level output under UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo #(
  parameter int unsigned Wdata = 8,
  parameter int unsigned Depth = 16
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  parameter int unsigned Wmark = Depth / 2
`endif
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [Wdata-1:0]           DIN,
  input  logic                       STB,
  output logic [Wdata-1:0]           DOUT,
  output logic                       VALID,
  input  logic                       READY,
  output logic [$clog2(Depth+1)-1:0] LEVEL,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       OVERRUN,
`ifdef UART_RX_FIFO_WATERMARK_EN
  output logic                       WMARK,
`endif
  input  logic                       CLR_OVR
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Lw = $clog2(Depth + 1);

  logic [Wdata-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Lw-1:0]    level_q, level_d;
  logic             valid_q;
  logic             overrun_q, overrun_d;
  logic             full, pop, push, ovr_evt;

  assign full = (level_q == Lw'(Depth));

  always_comb begin
    pop       = valid_q & READY;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the strobe.
    push      = STB & (~full | pop);
    ovr_evt   = STB & full & ~pop;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (CLR_OVR) overrun_d = 1'b0;
    if (ovr_evt) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      // Storage is cleared too so DOUT reads zero out of reset.
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= DIN;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q   <= level_d;
      valid_q   <= (level_d != '0);
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  logic wmark_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wmark_q <= 1'b0;
    end else begin
      wmark_q <= (level_d >= Lw'(Wmark));
    end
  end

  assign WMARK = wmark_q;
`endif

  assign DOUT    = mem_q[rd_ptr_q];
  assign VALID   = valid_q;
  assign LEVEL   = level_q;
  assign EMPTY   = (level_q == '0);
  assign FULL    = full;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected words, a negedge monitor checks
// every accepted head word; status outputs are checked directly after each stimulus edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       stb;
  logic [7:0] dout;
  logic       valid;
  logic       ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       clr_ovr;
`ifdef UART_RX_FIFO_WATERMARK_EN
  logic       wmark;
`endif

  uart_rx_fifo #(
    .Wdata(8),
    .Depth(16)
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    .Wmark(4)
`endif
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .DIN    (din),
    .STB    (stb),
    .DOUT   (dout),
    .VALID  (valid),
    .READY  (ready),
    .LEVEL  (level),
    .EMPTY  (empty),
    .FULL   (full),
    .OVERRUN(overrun),
`ifdef UART_RX_FIFO_WATERMARK_EN
    .WMARK  (wmark),
`endif
    .CLR_OVR(clr_ovr)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accepted);
    stb = 1'b1;
    din = d;
    if (accepted) exp_q.push_back(d);
    step();
    stb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready = 1'b1;
    while (!empty && n < 40) begin
      step();
      n++;
    end
    ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  // Monitor: a word is accepted at the next rising edge whenever VALID&&READY here.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          chk("dout_order", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din = '0; stb = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    step();
    step();
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_dout",    32'(dout),    32'd0);
    rst = 1'b0;
    step();

    // Single word, show-ahead latency of one edge.
    push(8'hA5, 1'b1);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_dout",  32'(dout),  32'hA5);
    chk("single_level", 32'(level), 32'd1);
    chk("single_empty", 32'(empty), 32'd0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("pop_valid", 32'(valid), 32'd0);
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_empty", 32'(empty), 32'd1);

    // Fill and drain in order.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);
    drain();

    // Offset the pointers, then fill/drain across the wrap.
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b1);
    drain();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    chk("wrap_level", 32'(level), 32'd16);
    drain();

    // Overrun: dropped word, sticky flag, clear, and set-wins-over-clear.
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
    push(8'hEE, 1'b0);
    chk("ovr_set",   32'(overrun), 32'd1);
    chk("ovr_level", 32'(level),   32'd16);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    clr_ovr = 1'b1;
    push(8'hEE, 1'b0);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("ovr_level2",   32'(level),   32'd16);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop.
    ready = 1'b1;
    push(8'h77, 1'b1);
    ready = 1'b0;
    chk("pp_overrun", 32'(overrun), 32'd0);
    chk("pp_level",   32'(level),   32'd16);
    chk("pp_head",    32'(dout),    32'h21);
    drain();

    // Reset mid-operation with a coincident strobe.
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i), 1'b1);
    chk("mid_level", 32'(level), 32'd7);
    rst = 1'b1;
    push(8'h99, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_level",   32'(level),   32'd0);
    chk("midrst_valid",   32'(valid),   32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    push(8'h3C, 1'b1);
    push(8'h3D, 1'b1);
    chk("midrst_head", 32'(dout), 32'h3C);
    drain();

`ifdef UART_RX_FIFO_WATERMARK_EN
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 1'b1);
    chk("wmark_below", 32'(wmark), 32'd0);
    push(8'h43, 1'b1);
    chk("wmark_at", 32'(wmark), 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wmark_pop", 32'(wmark), 32'd0);
    drain();
`endif

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
